// File: rtl/spu_reg_fetch.sv
// Register-fetch stage of the dual-issue SPU pipeline, feeding the REG->EX pipeline register.
//
// Holds the unified register file (NUM_REGS x DATA_W) with six combinational read ports
// (RA/RB/RC for each pipe) and two write ports. Writeback data is bypassed to the readers
// in the same cycle. A pending-write scoreboard tracks registers with a write in flight, and
// the REG stage stalls on RAW/WAW hazards. The two-instruction pair issues atomically.
//
// Ports:
//   clk, reset                     clock; synchronous active-high reset
//   issue_valid1/2, issue_wr1/2    valid instruction in REG (pipe 1 older); writes its RT
//   rd_addr_ra/rb/rc/rt1, ...2     source/target register numbers per pipe
//   wb_en1/2, wb_addr1/2, wb_data1/2   writeback ports (pipe 2 younger, wins on collision)
//   rd_data_ra/rb/rc1, ...2        operand data per pipe (wb2 > wb1 > array)
//   stall                          hold fetch/decode and REG; REG->EX captures a bubble
//   issue_fire1/2                  instruction accepted this cycle
module spu_reg_fetch #(
  parameter int unsigned NUM_REGS = 128,
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned ADDR_W   = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid1,
  input  logic              issue_valid2,
  input  logic              issue_wr1,
  input  logic              issue_wr2,
  input  logic [ADDR_W-1:0] rd_addr_ra1,
  input  logic [ADDR_W-1:0] rd_addr_rb1,
  input  logic [ADDR_W-1:0] rd_addr_rc1,
  input  logic [ADDR_W-1:0] rd_addr_rt1,
  input  logic [ADDR_W-1:0] rd_addr_ra2,
  input  logic [ADDR_W-1:0] rd_addr_rb2,
  input  logic [ADDR_W-1:0] rd_addr_rc2,
  input  logic [ADDR_W-1:0] rd_addr_rt2,
  input  logic              wb_en1,
  input  logic [ADDR_W-1:0] wb_addr1,
  input  logic [DATA_W-1:0] wb_data1,
  input  logic              wb_en2,
  input  logic [ADDR_W-1:0] wb_addr2,
  input  logic [DATA_W-1:0] wb_data2,
  output logic [DATA_W-1:0] rd_data_ra1,
  output logic [DATA_W-1:0] rd_data_rb1,
  output logic [DATA_W-1:0] rd_data_rc1,
  output logic [DATA_W-1:0] rd_data_ra2,
  output logic [DATA_W-1:0] rd_data_rb2,
  output logic [DATA_W-1:0] rd_data_rc2,
  output logic              stall,
  output logic              issue_fire1,
  output logic              issue_fire2
);

  localparam int unsigned NumRdPorts = 6;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic [NUM_REGS-1:0] clr;
  logic [NUM_REGS-1:0] set;
  logic [NUM_REGS-1:0] epend;

  // Writebacks are ignored while reset is high, both for the array and for the bypass.
  logic wb_act1;
  logic wb_act2;
  assign wb_act1 = wb_en1 & ~reset;
  assign wb_act2 = wb_en2 & ~reset;

  // ---------------------------------------------------------------------------------------
  // Read ports with same-cycle writeback bypass
  // ---------------------------------------------------------------------------------------
  logic [ADDR_W-1:0] rd_addr [NumRdPorts];
  logic [DATA_W-1:0] rd_data [NumRdPorts];

  assign rd_addr[0] = rd_addr_ra1;
  assign rd_addr[1] = rd_addr_rb1;
  assign rd_addr[2] = rd_addr_rc1;
  assign rd_addr[3] = rd_addr_ra2;
  assign rd_addr[4] = rd_addr_rb2;
  assign rd_addr[5] = rd_addr_rc2;

  always_comb begin
    for (int unsigned p = 0; p < NumRdPorts; p++) begin
      rd_data[p] = regs_q[rd_addr[p]];
      // Later assignment wins: wb2 overrides wb1 overrides the array.
      if (wb_act1 && (wb_addr1 == rd_addr[p])) begin
        rd_data[p] = wb_data1;
      end
      if (wb_act2 && (wb_addr2 == rd_addr[p])) begin
        rd_data[p] = wb_data2;
      end
    end
  end

  assign rd_data_ra1 = rd_data[0];
  assign rd_data_rb1 = rd_data[1];
  assign rd_data_rc1 = rd_data[2];
  assign rd_data_ra2 = rd_data[3];
  assign rd_data_rb2 = rd_data[4];
  assign rd_data_rc2 = rd_data[5];

  // ---------------------------------------------------------------------------------------
  // Scoreboard: per-register set/clear decode and effective pending
  // ---------------------------------------------------------------------------------------
  always_comb begin
    clr = '0;
    set = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      clr[r] = (wb_act1 && (wb_addr1 == r[ADDR_W-1:0])) ||
               (wb_act2 && (wb_addr2 == r[ADDR_W-1:0]));
      set[r] = (issue_fire1 && issue_wr1 && (rd_addr_rt1 == r[ADDR_W-1:0])) ||
               (issue_fire2 && issue_wr2 && (rd_addr_rt2 == r[ADDR_W-1:0]));
    end
  end

  // A register being written back this cycle is not a hazard: its data is on the bypass.
  assign epend = pending_q & ~clr;

  // Set wins over clear so a new writer issued alongside an old writeback stays tracked.
  assign pending_d = set | (pending_q & ~clr);

  // ---------------------------------------------------------------------------------------
  // Hazard detection and issue
  // ---------------------------------------------------------------------------------------
  logic hazard1;
  logic hazard2;
  logic cross_dep;

  always_comb begin
    hazard1 = issue_valid1 &
              (epend[rd_addr_ra1] | epend[rd_addr_rb1] | epend[rd_addr_rc1] |
               (issue_wr1 & epend[rd_addr_rt1]));

    // Pipe 2 depending on pipe 1's result within the same pair cannot be bypassed.
    cross_dep = issue_valid1 & issue_wr1 &
                ((rd_addr_rt1 == rd_addr_ra2) | (rd_addr_rt1 == rd_addr_rb2) |
                 (rd_addr_rt1 == rd_addr_rc2) | (issue_wr2 & (rd_addr_rt1 == rd_addr_rt2)));

    hazard2 = issue_valid2 &
              (epend[rd_addr_ra2] | epend[rd_addr_rb2] | epend[rd_addr_rc2] |
               (issue_wr2 & epend[rd_addr_rt2]) | cross_dep);
  end

  assign stall       = ~reset & (hazard1 | hazard2);
  assign issue_fire1 = ~reset & issue_valid1 & ~stall;
  assign issue_fire2 = ~reset & issue_valid2 & ~stall;

  // ---------------------------------------------------------------------------------------
  // State: register array and pending bits
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      pending_q <= pending_d;
      if (wb_en1) begin
        regs_q[wb_addr1] <= wb_data1;
      end
      // Second write wins on an address collision: pipe 2 is younger.
      if (wb_en2) begin
        regs_q[wb_addr2] <= wb_data2;
      end
    end
  end

endmodule
